// File: rtl/gray_seq_encoder_if.sv
// Handshake/bus bundle for gray_seq_encoder.
// gray_par exists only when GRAY_PARITY_EN is defined.
interface gray_seq_encoder_if;
    logic [3:0] bin_in;
    logic       load;
    logic       cnt_en;
    logic       up_dn;
    logic       in_ready;
    logic [3:0] gray_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       wrap;
`ifdef GRAY_PARITY_EN
    logic       gray_par;
`endif

    modport master (
        output bin_in, load, cnt_en, up_dn, out_ready,
        input  in_ready, gray_out, out_valid, err, wrap
`ifdef GRAY_PARITY_EN
        , input gray_par
`endif
    );

    modport slave (
        input  bin_in, load, cnt_en, up_dn, out_ready,
        output in_ready, gray_out, out_valid, err, wrap
`ifdef GRAY_PARITY_EN
        , output gray_par
`endif
    );
endinterface

// File: rtl/gray_seq_encoder.sv
// Loadable up/down counter emitting registered Gray codes over valid/ready.
// Optional GRAY_PARITY_EN adds a registered parity of gray_out.
module gray_seq_encoder #(
    parameter int unsigned MAX_CODE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    gray_seq_encoder_if.slave bus
);
    localparam logic [3:0] MAX = 4'(MAX_CODE);

    typedef enum logic {IDLE, PEND} state_t;

    state_t     state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    logic [3:0] gray_q, gray_n;
    logic       err_q, err_n;
    logic       wrap_q, wrap_n;
    logic       in_ready;
    logic       issue;
`ifdef GRAY_PARITY_EN
    logic       par_q;
`endif

    assign in_ready = (state_q == IDLE) | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gray_q  <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef GRAY_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            gray_q  <= gray_n;
            err_q   <= err_n;
            wrap_q  <= wrap_n;
`ifdef GRAY_PARITY_EN
            par_q   <= ^gray_n;
`endif
        end
    end

    always_comb begin
        cnt_n  = cnt_q;
        err_n  = 1'b0;
        wrap_n = 1'b0;
        issue  = 1'b0;
        // load outranks counting; rejected loads issue nothing
        if (in_ready && bus.load) begin
            if (bus.bin_in <= MAX) begin
                cnt_n = bus.bin_in;
                issue = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end else if (in_ready && bus.cnt_en) begin
            issue = 1'b1;
            if (bus.up_dn) begin
                if (cnt_q == MAX) begin
                    cnt_n  = 4'd0;
                    wrap_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end else begin
                if (cnt_q == 4'd0) begin
                    cnt_n  = MAX;
                    wrap_n = 1'b1;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
        end
        gray_n = issue ? (cnt_n ^ (cnt_n >> 1)) : gray_q;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: if (issue) state_n = PEND;
            PEND: begin
                if (issue)
                    state_n = PEND;
                else if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.gray_out  = gray_q;
    assign bus.out_valid = (state_q == PEND);
    assign bus.err       = err_q;
    assign bus.wrap      = wrap_q;
`ifdef GRAY_PARITY_EN
    assign bus.gray_par  = par_q;
`endif
endmodule
